// File: rtl/wb_slave_bcd_stopwatch.sv
// Wishbone classic slave holding a mm:ss stopwatch as four BCD digits.
// Registers: CTRL (run/clear/down), TIME, STATUS (wrap/zero[/alarm]), TICK.
// Optional feature macro ALARM_EN adds the ALARM register, STATUS bit2 and irq.
module wb_slave_bcd_stopwatch #(
    parameter int MAX_MIN      = 59,
    parameter bit DOWN_DEFAULT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic [3:0]  sec1,
    output logic [3:0]  sec2,
    output logic [3:0]  min1,
    output logic [3:0]  min2
`ifdef ALARM_EN
    ,
    output logic        irq
`endif
);

    localparam logic [3:0]  MAX_M2   = 4'(MAX_MIN / 10);
    localparam logic [3:0]  MAX_M1   = 4'(MAX_MIN % 10);
    localparam logic [15:0] TIME_MAX = {MAX_M2, MAX_M1, 4'd5, 4'd9};

    // A time value is accepted only if every digit is BCD, sec2 <= 5 and mm <= MAX_MIN.
    function automatic logic time_ok(input logic [15:0] t);
        int mins;
        mins = int'(t[15:12]) * 10 + int'(t[11:8]);
        return (t[3:0] <= 4'd9) && (t[7:4] <= 4'd5) && (t[11:8] <= 4'd9) &&
               (t[15:12] <= 4'd9) && (mins <= MAX_MIN);
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[3:0] != 4'd9) r[3:0] = t[3:0] + 4'd1;
        else begin
            r[3:0] = 4'd0;
            if (t[7:4] != 4'd5) r[7:4] = t[7:4] + 4'd1;
            else begin
                r[7:4] = 4'd0;
                if (t[11:8] != 4'd9) r[11:8] = t[11:8] + 4'd1;
                else begin
                    r[11:8]  = 4'd0;
                    r[15:12] = t[15:12] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    // Caller guarantees t is not 00:00.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[3:0] != 4'd0) r[3:0] = t[3:0] - 4'd1;
        else begin
            r[3:0] = 4'd9;
            if (t[7:4] != 4'd0) r[7:4] = t[7:4] - 4'd1;
            else begin
                r[7:4] = 4'd5;
                if (t[11:8] != 4'd0) r[11:8] = t[11:8] - 4'd1;
                else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = t[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    logic [15:0] tm_q, tm_d;
    logic        run_q, run_d, down_q, down_d, wrap_q, wrap_set;
    logic        acc, wr, wr_ctrl, wr_time, wr_stat, wr_tick, step, zero, stepped;
    logic [2:0]  adr;
    logic [31:0] rd_data;
    logic        unused_bits;
`ifdef ALARM_EN
    logic [15:0] alarm_q;
    logic        alarm_flag_q, alarm_hit, wr_alarm;
`endif

    assign adr     = wb_adr_i[4:2];
    assign acc     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr      = acc & wb_we_i & wb_sel_i[0] & wb_sel_i[1];
    assign wr_ctrl = wr && (adr == 3'd0);
    assign wr_time = wr && (adr == 3'd1);
    assign wr_stat = wr && (adr == 3'd2);
    assign wr_tick = wr && (adr == 3'd3);
    assign step    = run_q & (tick | wr_tick);
    assign zero    = (tm_q == 16'h0000);
    assign {min2, min1, sec2, sec1} = tm_q;
    assign unused_bits = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i[31:16], wb_sel_i[3:2]};
`ifdef ALARM_EN
    assign wr_alarm = wr && (adr == 3'd4);
    assign irq      = alarm_flag_q;
`endif

    // Next time/control state: clear beats TIME write beats a tick step.
    always_comb begin
        tm_d     = tm_q;
        run_d    = run_q;
        down_d   = down_q;
        wrap_set = 1'b0;
        stepped  = 1'b0;
        if (wr_ctrl && wb_dat_i[1]) begin
            tm_d = 16'h0000;
        end else if (wr_time && time_ok(wb_dat_i[15:0])) begin
            tm_d = wb_dat_i[15:0];
        end else if (step) begin
            if (!down_q) begin
                stepped = 1'b1;
                if (tm_q == TIME_MAX) begin
                    tm_d     = 16'h0000;
                    wrap_set = 1'b1;
                end else begin
                    tm_d = bcd_inc(tm_q);
                end
            end else if (zero) begin
                run_d = 1'b0;
            end else begin
                stepped = 1'b1;
                tm_d    = bcd_dec(tm_q);
                if (tm_d == 16'h0000) run_d = 1'b0;
            end
        end
        if (wr_ctrl) begin
            run_d  = wb_dat_i[0];
            down_d = wb_dat_i[2];
        end
    end

`ifdef ALARM_EN
    assign alarm_hit = stepped && (tm_d == alarm_q);
`endif

    // Register read mux; unmapped offsets and write-only TICK read as zero.
    always_comb begin
        rd_data = 32'h0;
        case (adr)
            3'd0: rd_data = {29'h0, down_q, 1'b0, run_q};
            3'd1: rd_data = {16'h0, tm_q};
`ifdef ALARM_EN
            3'd2: rd_data = {29'h0, alarm_flag_q, zero, wrap_q};
            3'd4: rd_data = {16'h0, alarm_q};
`else
            3'd2: rd_data = {30'h0, zero, wrap_q};
`endif
            default: rd_data = 32'h0;
        endcase
    end

    // Bus handshake: ack one cycle after an accepted strobe, never two in a row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= 32'h0;
        end else begin
            wb_ack_o <= acc;
            wb_dat_o <= acc ? rd_data : 32'h0;
        end
    end

    // Stopwatch state and sticky status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tm_q   <= 16'h0000;
            run_q  <= 1'b0;
            down_q <= DOWN_DEFAULT;
            wrap_q <= 1'b0;
        end else begin
            tm_q   <= tm_d;
            run_q  <= run_d;
            down_q <= down_d;
            wrap_q <= (wrap_q & ~(wr_stat & wb_dat_i[0])) | wrap_set;
        end
    end

`ifdef ALARM_EN
    // Alarm register and sticky alarm flag driving irq.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alarm_q      <= 16'h0000;
            alarm_flag_q <= 1'b0;
        end else begin
            if (wr_alarm && time_ok(wb_dat_i[15:0])) alarm_q <= wb_dat_i[15:0];
            alarm_flag_q <= (alarm_flag_q & ~(wr_stat & wb_dat_i[2])) | alarm_hit;
        end
    end
`endif

endmodule
